// File: rtl/mul_div_sequencer.sv
// Purpose: iterative RV32M multiply/divide unit beside the execute-stage ALU (shift-add multiply, restoring divide).
// Latency: done in cycle WIDTH+1 after acceptance for normal ops, cycle 1 for divide-by-zero / signed-overflow fast paths.
// Backpressure: one op at a time; stall holds upstream while accepting and iterating, drops in the done cycle.
module mul_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;

    state_t             state;
    state_t             state_nxt;

    // Latched operation context
    logic [2:0]         op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   opnd;       // multiplicand (mul) or divisor (div)
    logic [2*WIDTH-1:0] acc;        // {hi, lo}: product accumulator or {remainder, quotient}
    logic [CW-1:0]      cnt;

    // Acceptance-time decode
    logic               a_sgn_in;
    logic               b_sgn_in;
    logic               a_neg_in;
    logic               b_neg_in;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               div_zero;
    logic               div_ovf;
    logic               fast;
    logic [WIDTH-1:0]   fast_res;
    logic               accept;

    // Iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   final_res;
    logic               last;

    assign accept = (state == IDLE) && start && !flush;
    assign last   = (cnt == CW'(WIDTH - 1));

    // Decode operand signedness, magnitudes and the division fast paths at acceptance
    always_comb begin
        // MUL/MULH sign both, MULHSU signs A only, MULHU none; DIV/REM sign both, DIVU/REMU none
        a_sgn_in = Funct3[2] ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
        b_sgn_in = Funct3[2] ? ~Funct3[0] : ~Funct3[1];
        a_neg_in = a_sgn_in & SrcA[WIDTH-1];
        b_neg_in = b_sgn_in & SrcB[WIDTH-1];
        a_mag    = a_neg_in ? -SrcA : SrcA;
        b_mag    = b_neg_in ? -SrcB : SrcB;
        div_zero = (SrcB == '0);
        div_ovf  = ~Funct3[0] && (SrcA == MIN_NEG) && (SrcB == '1);
        fast     = Funct3[2] && (div_zero || div_ovf);
        if (Funct3[1])
            fast_res = div_zero ? SrcA : '0;
        else
            fast_res = div_zero ? '1 : MIN_NEG;
    end

    // One shift-add or restoring-divide step, plus sign correction of the post-step value
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_part = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_part - {1'b0, opnd};
        if (op[2]) begin
            // Borrow clear means the shifted remainder covers the divisor: subtract and set the quotient bit
            if (!div_diff[WIDTH])
                acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_step = {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
        prod = (a_neg ^ b_neg) ? -acc_step : acc_step;
        quot = (a_neg ^ b_neg) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        rem  = a_neg ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
        if (op[2])
            final_res = op[1] ? rem : quot;
        else
            final_res = (op[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; flush overrides everything including a same-cycle start
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = fast ? FINISH : ITER;
            ITER:    if (flush) state_nxt = IDLE;
                     else if (last) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy  = (state == ITER);
        done  = (state == FINISH);
        stall = ((state == IDLE) && start) || (state == ITER);
    end

    // Datapath: latch operands on accept, iterate, and register Result on the way into FINISH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op     <= '0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            Result <= '0;
        end else if (accept) begin
            op    <= Funct3;
            a_neg <= a_neg_in;
            b_neg <= b_neg_in;
            cnt   <= '0;
            if (Funct3[2]) begin
                opnd <= b_mag;
                acc  <= {{WIDTH{1'b0}}, a_mag};
            end else begin
                opnd <= a_mag;
                acc  <= {{WIDTH{1'b0}}, b_mag};
            end
            if (fast)
                Result <= fast_res;
        end else if ((state == ITER) && !flush) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (last)
                Result <= final_res;
        end
    end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Purpose: self-checking bench for mul_div_sequencer against an arithmetic reference model.
// Latency: checks done-cycle timing (WIDTH+1 normal, 1 fast path) for every operation.
// Backpressure: checks stall/busy across every iteration cycle and the flush/reset abort paths.
module tb_mul_div_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] Result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_div_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RV32M semantics computed with 64-bit host arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op in the next cycle, optionally inject illegal starts while iterating, check timing and result
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit inject, input string tag);
        logic [31:0] exp_res;
        int exp_lat;
        int lat;
        bit stall_ok;
        exp_res = ref_model(f, a, b);
        exp_lat = ref_lat(f, a, b);
        @(negedge clk);
        start = 1'b1; Funct3 = f; SrcA = a; SrcB = b;
        #1;
        check({tag, "_stall_accept"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0; SrcA = $urandom; SrcB = $urandom;
        lat = 0;
        stall_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (!stall || !busy) stall_ok = 1'b0;
            start  = inject && (c >= 3) && (c <= 5);
            Funct3 = ~f;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, Result, exp_res);
        check({tag, "_iter_stall_busy"}, 32'(stall_ok), 32'd1);
        check({tag, "_done_stall"}, 32'(stall), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] prev;
        bit no_done;
        reset = 1'b0; start = 1'b0; flush = 1'b0;
        Funct3 = 3'd0; SrcA = 32'd0; SrcB = 32'd0;

        repeat (2) @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_result", Result, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed operations, back to back
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0, "mul_7_m3");
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulh_min");
        do_op(3'b011, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulhu_min");
        do_op(3'b010, 32'hFFFF_FFFF, 32'd2, 1'b0, "mulhsu_m1_2");
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0, "rem_m7_2");
        do_op(3'b101, 32'd100, 32'd7, 1'b0, "divu_100_7");
        do_op(3'b111, 32'd100, 32'd7, 1'b0, "remu_100_7");
        do_op(3'b100, 32'd5, 32'd0, 1'b0, "div_by0");
        do_op(3'b110, 32'd5, 32'd0, 1'b0, "rem_by0");
        do_op(3'b101, 32'hDEAD_BEEF, 32'd0, 1'b0, "divu_by0");
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
        do_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divu_noovf");

        // Flush a DIVU in cycle 10, then start MUL 3*4 in cycle 12
        prev = Result;
        no_done = 1'b1;
        @(negedge clk);
        start = 1'b1; Funct3 = 3'b101; SrcA = 32'd1000; SrcB = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done) no_done = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_no_done", 32'(no_done && !done), 32'd1);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_stall", 32'(stall), 32'd0);
        check("flush_result_held", Result, prev);
        do_op(3'b000, 32'd3, 32'd4, 1'b0, "mul_after_flush");

        // flush and start together in IDLE: nothing accepted
        @(negedge clk);
        start = 1'b1; flush = 1'b1; Funct3 = 3'b000; SrcA = 32'd9; SrcB = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 32'(busy), 32'd0);
        check("flush_start_done", 32'(done), 32'd0);
        @(negedge clk);
        check("flush_start_done2", 32'(done), 32'd0);
        check("flush_start_result", Result, 32'd12);

        // Asynchronous reset in cycle 5 of a MUL
        @(negedge clk);
        start = 1'b1; Funct3 = 3'b000; SrcA = 32'd5; SrcB = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_done", 32'(done), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_result", Result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_op(3'b000, 32'd9, 32'd11, 1'b1, "mul_ignore_start");
        do_op(3'b100, 32'hFFFF_FF00, 32'd7, 1'b1, "div_ignore_start");

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            logic [2:0] f;
            f = 3'($urandom_range(0, 7));
            do_op(f, pick_operand(), pick_operand(), 1'b0, $sformatf("rand%0d_f%0d", i, f));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_sequencer.md
Name: mul_div_sequencer

Overview:
Iterative sequencer for the RV32M multiply/divide datapath, sitting beside the ALU in the execute stage. It accepts one M-extension operation at a time, runs a shift-add multiply or a restoring divide over WIDTH cycles, applies sign correction, and returns a single 32-bit result. While it runs, it holds the pipeline with a stall signal.

Parameters:
WIDTH, 32, operand/result width; iteration count per multiply or divide

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request: execute the operation given by Funct3/SrcA/SrcB
Funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcA  in  WIDTH  rs1 operand (multiplicand/dividend)
SrcB  in  WIDTH  rs2 operand (multiplier/divisor)
flush  in  1  abort any in-flight operation (branch/exception squash)
stall  out  1  hold upstream pipeline stages
busy  out  1  high in ITER state
done  out  1  one-cycle pulse: Result valid
Result  out  WIDTH  final result; held until next accepted start

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - done=0, busy=0, Result=0; all internal registers cleared.
  - Reset asserted mid-operation aborts it; no done pulse is produced.
- States: IDLE, ITER, FINISH.
- IDLE:
  - start=1 accepts the request at the edge. Latch Funct3, the operand sign flags, |SrcA| and |SrcB| (magnitude only for signed ops: MUL* signed per operand, MULHSU SrcA only, DIV/REM both), and clear counter.
  - Next state is ITER, except for the division fast paths below, which go directly to FINISH.
- Division fast paths (decided at acceptance):
  - SrcB=0: quotient=all ones, remainder=SrcA.
  - Signed DIV/REM with SrcA=0x8000_0000 and SrcB=0xFFFF_FFFF: quotient=0x8000_0000, remainder=0.
- ITER:
  - One iteration per cycle.
  - Multiply: 2*WIDTH-bit accumulator, shift-add.
  - Divide: restoring, one quotient bit per cycle.
  - Counter runs 0..WIDTH-1; at count WIDTH-1 the next state is FINISH.
- FINISH:
  - Negate the product if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - Register Result: MUL=low WIDTH bits, MULH/MULHSU/MULHU=high WIDTH bits, DIV*=quotient, REM*=remainder.
  - done=1 for exactly this one cycle; next state is IDLE.
- Latency (acceptance cycle = cycle 0):
  - Normal op: done in cycle WIDTH+1 (33 for WIDTH=32).
  - Fast path: done in cycle 1.
- stall (combinational): (state==IDLE && start) || state==ITER. stall is 0 in FINISH, so the pipeline advances with Result in the done cycle.
- start while in ITER or FINISH is ignored; upstream is stalled, so this is only reachable via a protocol error.
- flush=1 in any state: next state is IDLE, no done pulse, Result unchanged. If flush and start are both high in IDLE, flush wins and nothing is accepted.
- Back-to-back operation: start may be high in the cycle after FINISH (IDLE) and is accepted normally.
- All arithmetic is unsigned on magnitudes. Two's-complement negation is modulo 2^WIDTH (or 2^(2*WIDTH) for products).

Test Plan:
- MUL, SrcA=7, SrcB=0xFFFF_FFFD (-3), start pulse at cycle 0 -> stall high cycles 0-32; done only in cycle 33; Result=0xFFFF_FFEB.
- MULH with SrcA=SrcB=0x8000_0000 -> Result=0x4000_0000. MULHU with the same operands -> 0x4000_0000. MULHSU with SrcA=0xFFFF_FFFF, SrcB=2 -> 0xFFFF_FFFF.
- DIV/REM, SrcA=0xFFFF_FFF9 (-7), SrcB=2 -> DIV=0xFFFF_FFFD, REM=0xFFFF_FFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero, SrcA=5, SrcB=0 -> done in cycle 1 with DIV=0xFFFF_FFFF, REM=5. Overflow DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000; REM -> 0.
- flush in cycle 10 of a DIVU -> IDLE next cycle, no done, stall low; a new MUL 3*4 started at cycle 12 gives done in cycle 45 with Result=12.
- reset driven low in cycle 5 of a MUL -> done=0, busy=0, Result=0 immediately (asynchronous); after release, start high while in ITER is ignored, and the result matches the first operation only.
